// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: main + skid entry with valid/ready handshake,
// synchronous flush and a saturating backpressure counter.
module pipe_stage_elastic #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_free;
  logic w_stall;

  // in_ready depends only on registered state, breaking the ready path.
  assign in_ready    = ~r_skid_valid;
  assign w_in_fire   = in_valid & ~r_skid_valid;
  assign w_out_fire  = r_main_valid & out_ready;
  assign w_main_free = ~r_main_valid | w_out_fire;
  assign w_stall     = r_main_valid & ~out_ready & ~flush;

  assign out_valid = r_main_valid;
  assign out_ctrl  = r_main_ctrl & {CTRL_W{r_main_valid}};
  assign out_data  = r_main_data;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Data is left in place; only validity and control are dropped.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_ctrl  <= '0;
    end else if (r_skid_valid && w_main_free) begin
      r_main_valid <= 1'b1;
      r_main_ctrl  <= r_skid_ctrl;
      r_main_data  <= r_skid_data;
      r_skid_valid <= 1'b0;
    end else if (w_in_fire && w_main_free) begin
      r_main_valid <= 1'b1;
      r_main_ctrl  <= in_ctrl;
      r_main_data  <= in_data;
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= in_ctrl;
      r_skid_data  <= in_data;
    end else if (w_out_fire) begin
      r_main_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic: a default-width instance
// plus a narrow-counter instance for saturation.
module tb_pipe_stage_elastic;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ctrl;
  logic [68:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ctrl;
  logic [68:0] out_data;
  logic [15:0] stall_cnt;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [1:0]  s_in_ctrl;
  logic [7:0]  s_in_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [1:0]  s_out_ctrl;
  logic [7:0]  s_out_data;
  logic [2:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_elastic dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_elastic #(.DATA_W(8), .CTRL_W(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = '0; s_in_data = '0; s_out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 2'b00) begin errors++; $display("FAIL reset_out_ctrl got=%b exp=00", out_ctrl); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_ctrl = 2'b01;
    in_data = 69'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 69'(k)) begin
        errors++; $display("FAIL stream_beat%0d got v=%b d=%0d exp v=1 d=%0d", k, out_valid, out_data, k);
      end
      in_data = 69'(k + 1);
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 2'b10; in_data = 69'hA;
    tick();
    out_ready = 1'b0; in_data = 69'hB;
    tick();
    checks++; if (out_data !== 69'hA || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full got d=%h rdy=%b exp d=a rdy=0", out_data, in_ready);
    end
    in_data = 69'hC;
    tick();
    checks++; if (out_data !== 69'hA || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got d=%h v=%b rdy=%b exp d=a v=1 rdy=0", out_data, out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 69'hB || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_emit_b got d=%h v=%b rdy=%b exp d=b v=1 rdy=1", out_data, out_valid, in_ready);
    end
    tick();
    checks++; if (out_data !== 69'hC || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_emit_c got d=%h v=%b exp d=c v=1", out_data, out_valid);
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b01; in_data = 69'h11;
    tick();
    in_ctrl = 2'b10; in_data = 69'h22;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill got rdy=%b exp=0", in_ready); end
    flush = 1'b1; in_data = 69'h33; in_ctrl = 2'b11;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_two got v=%b c=%b rdy=%b exp v=0 c=00 rdy=1", out_valid, out_ctrl, in_ready);
    end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL flush_stall got=%0d exp=3", stall_cnt); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got=%b exp=0", out_valid); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'h44;
    tick();
    flush = 1'b1; in_data = 69'h55;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 69'h44) begin
      errors++; $display("FAIL flush_one got v=%b d=%h exp v=0 d=44", out_valid, out_data);
    end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL flush_one_stall got=%0d exp=3", stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got=%b exp=0", out_valid); end
  endtask

  task automatic test_ctrl_gating();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'hABC;
    tick();
    in_valid = 1'b0; in_ctrl = 2'b00;
    checks++; if (out_ctrl !== 2'b11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL ctrl_on got c=%b v=%b exp c=11 v=1", out_ctrl, out_valid);
    end
    tick();
    checks++; if (out_ctrl !== 2'b00 || out_valid !== 1'b0 || out_data !== 69'hABC) begin
      errors++; $display("FAIL ctrl_off got c=%b v=%b d=%h exp c=00 v=0 d=abc", out_ctrl, out_valid, out_data);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b01; in_data = 69'h66;
    tick();
    in_data = 69'h77;
    tick();
    tick();
    checks++; if (stall_cnt !== 16'd5 || in_ready !== 1'b0) begin
      errors++; $display("FAIL areset_pre got cnt=%0d rdy=%b exp cnt=5 rdy=0", stall_cnt, in_ready);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || out_data !== '0) begin
      errors++; $display("FAIL areset_out got v=%b c=%b d=%h exp 0", out_valid, out_ctrl, out_data);
    end
    checks++; if (in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL areset_state got rdy=%b cnt=%0d exp rdy=1 cnt=0", in_ready, stall_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 8'h5A; s_in_ctrl = 2'b01;
    tick();
    s_in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 6) begin
        checks++; if (s_stall_cnt !== 3'd6) begin errors++; $display("FAIL sat_6 got=%0d exp=6", s_stall_cnt); end
      end
      if (k == 7) begin
        checks++; if (s_stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_7 got=%0d exp=7", s_stall_cnt); end
      end
    end
    checks++; if (s_stall_cnt !== 3'd7 || s_out_data !== 8'h5A) begin
      errors++; $display("FAIL sat_hold got cnt=%0d d=%h exp cnt=7 d=5a", s_stall_cnt, s_out_data);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_ctrl_gating();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
